// File: rtl/alu_bcd_scan_display_if.sv
// Bus between the board switches/buttons and the ALU/BCD/7-segment display engine.
// The master side drives operands and control; the slave side returns status and display pins.
interface alu_bcd_scan_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
);
  logic              EN;
  logic              start;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [1:0]        OP_Code;
  logic              busy;
  logic              done;
  logic [WIDTH:0]    result;
  logic              neg;
  logic              ovf;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (
    output EN, start, A, B, OP_Code,
    input  busy, done, result, neg, ovf, seg, an
  );

  modport slave (
    input  EN, start, A, B, OP_Code,
    output busy, done, result, neg, ovf, seg, an
  );
endinterface

// File: rtl/alu_bcd_scan_display.sv
// ALU whose magnitude is converted to decimal by a serial double-dabble engine
// and shown on a scanned, common-anode multi-digit 7-segment display.
module alu_bcd_scan_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_bcd_scan_display_if.slave bus
);

  localparam int MW  = WIDTH + 1;
  localparam int BW  = 4 * DIGITS;
  localparam int SW  = BW + MW;
  localparam int ITW = $clog2(MW + 1);
  localparam int CW  = $clog2(REFRESH_DIV);
  localparam int IW  = $clog2(DIGITS);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // A negative value gives up the top digit to the sign.
  localparam logic [63:0] LIM_POS = pow10(DIGITS) - 64'd1;
  localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1) - 64'd1;

  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_CONV,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [MW-1:0]    r_magPend;
  logic             r_negPend;
  logic             r_ovfPend;
  logic [SW-1:0]    r_shift;
  logic [ITW-1:0]   r_iter;
  logic             r_busy;
  logic             r_done;
  logic [MW-1:0]    r_result;
  logic             r_neg;
  logic             r_ovf;
  logic [6:0]       r_disp [DIGITS];
  logic [CW-1:0]    r_refCnt;
  logic [IW-1:0]    r_digIdx;
  logic [6:0]       r_seg;
  logic [DIGITS-1:0] r_an;

  logic [MW-1:0]    w_mag;
  logic             w_neg;
  logic             w_ovf;
  logic [SW-1:0]    w_adj;
  logic [6:0]       w_dispNext [DIGITS];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_CALC;
      S_CALC: w_next = S_CONV;
      S_CONV: if (r_iter == ITW'(MW - 1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mag = '0;
    w_neg = 1'b0;
    case (r_op)
      2'b00: w_mag = {1'b0, r_a} + {1'b0, r_b};
      2'b01: begin
        if (r_a >= r_b) begin
          w_mag = {1'b0, r_a} - {1'b0, r_b};
        end else begin
          w_mag = {1'b0, r_b} - {1'b0, r_a};
          w_neg = 1'b1;
        end
      end
      2'b10: w_mag = {1'b0, r_a | r_b};
      default: w_mag = {1'b0, r_a ^ r_b};
    endcase
    w_ovf = w_neg ? (64'(w_mag) > LIM_NEG) : (64'(w_mag) > LIM_POS);
  end

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_shift[MW + 4*d +: 4] >= 4'd5)
        w_adj[MW + 4*d +: 4] = r_shift[MW + 4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      w_dispNext[d] = segOf(r_shift[MW + 4*d +: 4]);
      if (r_ovfPend)                      w_dispNext[d] = SEG_E;
      else if (r_negPend && d == DIGITS-1) w_dispNext[d] = SEG_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_magPend <= '0;
      r_negPend <= 1'b0;
      r_ovfPend <= 1'b0;
      r_shift   <= '0;
      r_iter    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      for (int d = 0; d < DIGITS; d++) r_disp[d] <= SEG_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a    <= bus.A;
            r_b    <= bus.B;
            r_op   <= bus.OP_Code;
            r_busy <= 1'b1;
          end
        end
        S_CALC: begin
          r_magPend <= w_mag;
          r_negPend <= w_neg;
          r_ovfPend <= w_ovf;
          r_shift   <= {{BW{1'b0}}, w_mag};
          r_iter    <= '0;
        end
        S_CONV: begin
          r_shift <= w_adj << 1;
          r_iter  <= r_iter + ITW'(1);
        end
        default: begin
          r_result <= r_magPend;
          r_neg    <= r_negPend;
          r_ovf    <= r_ovfPend;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          for (int d = 0; d < DIGITS; d++) r_disp[d] <= w_dispNext[d];
        end
      endcase
    end
  end

  // Scanner free-runs regardless of EN so blanking never shifts the digit phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refCnt <= '0;
      r_digIdx <= '0;
      r_seg    <= SEG_BLANK;
      r_an     <= '1;
    end else begin
      if (r_refCnt == CW'(REFRESH_DIV - 1)) begin
        r_refCnt <= '0;
        r_digIdx <= (r_digIdx == IW'(DIGITS - 1)) ? '0 : r_digIdx + IW'(1);
      end else begin
        r_refCnt <= r_refCnt + CW'(1);
      end
      r_seg <= bus.EN ? r_disp[r_digIdx] : SEG_BLANK;
      r_an  <= bus.EN ? ~(DIGITS'(1) << r_digIdx) : '1;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.neg    = r_neg;
  assign bus.ovf    = r_ovf;
  assign bus.seg    = r_seg;
  assign bus.an     = r_an;

endmodule

// File: tb/tb_alu_bcd_scan_display.sv
// Bench for alu_bcd_scan_display: a 4-digit and a 2-digit instance driven in lockstep
// and compared against a decimal-arithmetic reference model.
module tb_alu_bcd_scan_display;

  localparam int W  = 8;
  localparam int RD = 4;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_bcd_scan_display_if #(.WIDTH(W), .DIGITS(4)) bus4 ();
  alu_bcd_scan_display_if #(.WIDTH(W), .DIGITS(2)) bus2 ();

  alu_bcd_scan_display #(.WIDTH(W), .DIGITS(4), .REFRESH_DIV(RD)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  alu_bcd_scan_display #(.WIDTH(W), .DIGITS(2), .REFRESH_DIV(RD)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int compared = 0;
  int mismatched = 0;
  int edges = 0;
  bit enAt = 1'b0;

  logic         en;
  logic         st;
  logic [W-1:0] aIn;
  logic [W-1:0] bIn;
  logic [1:0]   opIn;

  logic [6:0] exp4 [4];
  logic [6:0] exp2 [2];
  int expRes;
  bit expNeg, expOvf4, expOvf2;

  function automatic logic [6:0] digitSeg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  task automatic applyStimulus();
    bus4.EN = en;  bus4.start = st;  bus4.A = aIn;  bus4.B = bIn;  bus4.OP_Code = opIn;
    bus2.EN = en;  bus2.start = st;  bus2.A = aIn;  bus2.B = bIn;  bus2.OP_Code = opIn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    enAt = en;
    if (rst_n) edges++;
    else       edges = 0;
    @(negedge clk);
  endtask

  task automatic setModel(input int mag, input bit n);
    int v;
    expRes  = mag;
    expNeg  = n;
    expOvf4 = n ? (mag > 999) : (mag > 9999);
    expOvf2 = n ? (mag > 9)   : (mag > 99);
    v = mag;
    for (int d = 0; d < 4; d++) begin
      if (expOvf4)          exp4[d] = SEG_E;
      else if (n && d == 3) exp4[d] = SEG_DASH;
      else                  exp4[d] = digitSeg(v % 10);
      v = v / 10;
    end
    v = mag;
    for (int d = 0; d < 2; d++) begin
      if (expOvf2)          exp2[d] = SEG_E;
      else if (n && d == 1) exp2[d] = SEG_DASH;
      else                  exp2[d] = digitSeg(v % 10);
      v = v / 10;
    end
  endtask

  task automatic modelOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0: setModel(ia + ib, 1'b0);
      2'd1: if (ia >= ib) setModel(ia - ib, 1'b0); else setModel(ib - ia, 1'b1);
      2'd2: setModel(ia | ib, 1'b0);
      default: setModel(ia ^ ib, 1'b0);
    endcase
  endtask

  // Digit k of the scan is active during edges k*RD+1 .. (k+1)*RD after reset release.
  task automatic checkDisplay(input int n);
    int idx;
    logic [3:0] ea4;
    logic [1:0] ea2;
    for (int i = 0; i < n; i++) begin
      tick();
      idx = (edges - 1) / RD;
      ea4 = enAt ? ~(4'b0001 << (idx % 4)) : 4'hF;
      ea2 = enAt ? ~(2'b01 << (idx % 2)) : 2'h3;
      checkOutput("an4", 32'(bus4.an), 32'(ea4));
      checkOutput("seg4", 32'(bus4.seg), 32'(enAt ? exp4[idx % 4] : SEG_BLANK));
      checkOutput("an2", 32'(bus2.an), 32'(ea2));
      checkOutput("seg2", 32'(bus2.seg), 32'(enAt ? exp2[idx % 2] : SEG_BLANK));
      checkOutput("idleDone", 32'(bus4.done), 32'd0);
      checkOutput("idleBusy", 32'(bus4.busy), 32'd0);
    end
  endtask

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input bit keep);
    aIn = a; bIn = b; opIn = op; st = 1'b1;
    applyStimulus();
    tick();
    checkOutput("accept4", 32'(bus4.busy), 32'd1);
    checkOutput("accept2", 32'(bus2.busy), 32'd1);
    if (!keep) begin
      st   = 1'b0;
      aIn  = 8'($urandom_range(0, 255));
      bIn  = 8'($urandom_range(0, 255));
      opIn = 2'($urandom_range(0, 3));
      applyStimulus();
    end
  endtask

  task automatic finishOp(input bit pulseMid);
    for (int c = 1; c <= W + 2; c++) begin
      tick();
      checkOutput("doneEarly4", 32'(bus4.done), 32'd0);
      checkOutput("doneEarly2", 32'(bus2.done), 32'd0);
      checkOutput("busyHold", 32'(bus4.busy), 32'd1);
      if (pulseMid && c == 2) begin
        st   = 1'b1;
        aIn  = 8'($urandom_range(0, 255));
        bIn  = 8'($urandom_range(0, 255));
        opIn = 2'($urandom_range(0, 3));
        applyStimulus();
      end
      if (pulseMid && c == 5) begin
        st = 1'b0;
        applyStimulus();
      end
    end
    tick();
    checkOutput("done4", 32'(bus4.done), 32'd1);
    checkOutput("done2", 32'(bus2.done), 32'd1);
    checkOutput("busyEnd", 32'(bus4.busy), 32'd0);
    checkOutput("result4", 32'(bus4.result), 32'(expRes));
    checkOutput("result2", 32'(bus2.result), 32'(expRes));
    checkOutput("neg4", 32'(bus4.neg), 32'(expNeg));
    checkOutput("neg2", 32'(bus2.neg), 32'(expNeg));
    checkOutput("ovf4", 32'(bus4.ovf), 32'(expOvf4));
    checkOutput("ovf2", 32'(bus2.ovf), 32'(expOvf2));
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input bit pulseMid);
    modelOp(a, b, op);
    startOp(a, b, op, 1'b0);
    finishOp(pulseMid);
    checkDisplay(16);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    en = 1'b1; st = 1'b0; aIn = '0; bIn = '0; opIn = '0;
    applyStimulus();
    rst_n = 1'b0;
    setModel(0, 1'b0);

    repeat (3) begin
      tick();
      checkOutput("rstBusy", 32'(bus4.busy), 32'd0);
      checkOutput("rstDone", 32'(bus4.done), 32'd0);
      checkOutput("rstResult", 32'(bus4.result), 32'd0);
      checkOutput("rstNeg", 32'(bus4.neg), 32'd0);
      checkOutput("rstOvf", 32'(bus4.ovf), 32'd0);
      checkOutput("rstSeg", 32'(bus4.seg), 32'(SEG_BLANK));
      checkOutput("rstAn4", 32'(bus4.an), 32'hF);
      checkOutput("rstAn2", 32'(bus2.an), 32'h3);
    end
    rst_n = 1'b1;
    checkDisplay(20);

    runOp(8'd200, 8'd100, 2'd0, 1'b0);
    runOp(8'd5,   8'd9,   2'd1, 1'b0);
    runOp(8'd60,  8'd50,  2'd0, 1'b0);
    runOp(8'hF0,  8'h0F,  2'd3, 1'b0);
    runOp(8'd50,  8'd49,  2'd0, 1'b0);
    runOp(8'd50,  8'd50,  2'd0, 1'b0);
    runOp(8'd3,   8'd12,  2'd1, 1'b0);
    runOp(8'd0,   8'd255, 2'd1, 1'b0);
    runOp(8'd255, 8'd255, 2'd0, 1'b0);
    runOp(8'd77,  8'd77,  2'd1, 1'b0);
    runOp(8'hA5,  8'h5A,  2'd2, 1'b0);

    // start pulsed mid-operation must neither restart nor corrupt the result
    runOp(8'd123, 8'd45, 2'd0, 1'b1);

    // start held through DONE is taken on the first IDLE edge
    modelOp(8'd9, 8'd200, 2'd1);
    startOp(8'd9, 8'd200, 2'd1, 1'b1);
    aIn = 8'd250; bIn = 8'd7; opIn = 2'd0;
    applyStimulus();
    finishOp(1'b0);
    tick();
    checkOutput("b2bAccept", 32'(bus4.busy), 32'd1);
    checkOutput("b2bNoDone", 32'(bus4.done), 32'd0);
    st = 1'b0;
    aIn = 8'($urandom_range(0, 255));
    bIn = 8'($urandom_range(0, 255));
    applyStimulus();
    modelOp(8'd250, 8'd7, 2'd0);
    finishOp(1'b0);
    checkDisplay(16);

    // reset during CONV aborts the operation
    startOp(8'd99, 8'd99, 2'd0, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("abortBusy", 32'(bus4.busy), 32'd0);
    checkOutput("abortDone", 32'(bus4.done), 32'd0);
    checkOutput("abortResult", 32'(bus4.result), 32'd0);
    checkOutput("abortSeg", 32'(bus4.seg), 32'(SEG_BLANK));
    checkOutput("abortAn", 32'(bus4.an), 32'hF);
    rst_n = 1'b1;
    setModel(0, 1'b0);
    checkDisplay(24);

    runOp(8'd42, 8'd17, 2'd1, 1'b0);
    en = 1'b0;
    applyStimulus();
    checkDisplay(10);
    en = 1'b1;
    applyStimulus();
    checkDisplay(16);

    repeat (15) begin
      runOp(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            2'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_bcd_scan_display.md
# alu_bcd_scan_display

Parametrised ALU whose result is converted to decimal by a sequential double-dabble engine and shown on a time-multiplexed, common-anode multi-digit 7-segment display. It supersedes the single-digit, purely combinational 4-bit ALU-to-7-segment path. Operands are WIDTH bits and the result is shown in decimal across DIGITS digits, with sign and overflow indication. It sits between the board switches/buttons and the display pins of the FPGA top level.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- DIGITS, 4, number of display digits (2..8)
- REFRESH_DIV, 100000, clock cycles per digit during scanning (≥2)

- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- EN  in  1  display enable; 0 blanks the display only
- start  in  1  request a new operation; sampled while idle
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- OP_Code  in  2  00 add, 01 subtract, 10 OR, 11 XOR
- busy  out  1  high from operation accept until done
- done  out  1  one-cycle pulse when the displayed value updates
- result  out  WIDTH+1  registered magnitude of the last result
- neg  out  1  last result negative (subtract only)
- ovf  out  1  last result does not fit on the display
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  DIGITS  digit enables, active-low one-hot; an[0] is the rightmost digit

## Operation
- FSM states: IDLE, CALC, CONV, DONE.
- IDLE → CALC: start=1 at a clock edge; A, B and OP_Code are captured on that edge. start is ignored in any state other than IDLE.
- CALC (1 cycle) computes the magnitude:
  - add: A+B, WIDTH+1 bits, neg=0.
  - sub: if A≥B, mag=A−B, neg=0; otherwise mag=B−A, neg=1.
  - OR / XOR: bitwise result, zero-extended, neg=0.
- CALC also computes ovf:
  - neg=0: ovf = mag > 10^DIGITS − 1.
  - neg=1: ovf = mag > 10^(DIGITS−1) − 1, because the top digit holds the sign.
- CALC then loads the shift register (4·DIGITS BCD bits plus mag) and moves to CONV.
- CONV: WIDTH+1 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by 1. After the last iteration the FSM moves to DONE.
- DONE (1 cycle): loads result, neg, ovf and the per-digit display registers; pulses done; returns to IDLE.
- Display register contents:
  - ovf=1: every digit shows 'E'.
  - neg=1: digit DIGITS−1 shows '-'; the remaining digits show BCD.
  - otherwise: all DIGITS digits show BCD, leading zeros shown.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, 'E'=0000110, blank=1111111.
- Scanner:
  - Refresh counter runs 0..REFRESH_DIV−1, then wraps.
  - On wrap, the digit index increments modulo DIGITS.
  - seg and an are registered from the current index and the display registers.
  - EN=0 forces seg=1111111 and an=all ones. The counter, index and FSM keep running.

## Timing
- Reset values:
  - FSM=IDLE; busy=0, done=0, result=0, neg=0, ovf=0.
  - Display registers all '0'; refresh counter=0; digit index=0.
  - seg=1111111; an=all ones.
- First edge after reset release with EN=1: an=…1110, seg=1000000.
- Latency: start accepted at edge N.
  - busy is 1 after edge N.
  - done is 1 for exactly one cycle after edge N+WIDTH+3. result, neg, ovf and the display registers update on that same edge.
  - busy is 0 after edge N+WIDTH+3.
  - For WIDTH=8, done is visible after edge N+11.
- Back-to-back: start held high during DONE is not accepted until IDLE. Earliest re-accept is edge N+WIDTH+4.
- seg/an lag the digit index by one cycle. Each digit is active for exactly REFRESH_DIV cycles.
- rst_n=0 mid-CALC/CONV/DONE: the operation is aborted, reset values apply, and no done pulse is produced.
- A, B and OP_Code changes after the accept edge have no effect on the result in flight.

## Test plan
All scenarios use WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless stated otherwise.

- Reset: rst_n=0 for 3 cycles, then EN=1 → reset values hold during reset. Afterwards an steps 1110, 1101, 1011, 0111, 1110…, changing every 4 cycles, with seg=1000000 throughout.
- Add: A=200, B=100, OP=00, start at edge N → done after edge N+11 only, result=300, neg=0, ovf=0. Digits 3..0 show 0,3,0,0: seg=0110000 while an=1011.
- Subtract: A=5, B=9, OP=01 → result=4, neg=1. Digit 3 shows 0111111 ('-'), digit 0 shows 0011001, digits 1 and 2 show 1000000.
- Overflow (DIGITS=2): A=60, B=50, OP=00 → result=110, ovf=1, both digits show 0000110 ('E'). XOR A=0xF0, B=0x0F → 255, ovf=1.
- Ignored start / abort: start pulsed again while busy → ignored, exactly one done. Separately, rst_n=0 during CONV → no done, display returns to 0000, busy=0.
- Enable: EN=0 for 10 cycles → seg=1111111 and an=1111 throughout. On EN=1, scanning resumes from the digit index it would have reached had EN never dropped.
